usb_fs_rx_decoder: RTL and testbench
====================================

// Module: usb_fs_rx_decoder
// PURPOSE
//  Full-speed USB receive front end: the first stage after the usb_p_rx/usb_n_rx pins.
//  Recovers the 12 Mb/s bit clock from 4x oversampling at 48 MHz, then performs:
//  - NRZI decode, SYNC detect, bit-unstuffing, EOP and bus-reset detect.
//  Delivers LSB-first bytes with packet framing to the protocol engine (PID/CRC/endpoint logic).
// PARAMETERS
//  SYNC_STAGES   2    metastability flops on usb_p_rx/usb_n_rx (>=2)
//  RESET_CYCLES  120  consecutive SE0 clocks (2.5 us) before usb_bus_reset asserts
// PORTS
//  clk_48mhz      in   1  sole clock, 48 MHz
//  reset_n        in   1  synchronous, active-low reset
//  usb_p_rx       in   1  raw D+ (asynchronous)
//  usb_n_rx       in   1  raw D- (asynchronous)
//  rx_en          in   1  0 while own transmitter drives bus; forces IDLE, suppresses all pulses
//  pkt_start      out  1  1-clk pulse: SYNC recognised
//  rx_data        out  8  received byte, LSB = first bit on wire; held until next put
//  rx_data_put    out  1  1-clk pulse: rx_data valid
//  pkt_end        out  1  1-clk pulse: packet terminated (EOP or error)
//  pkt_good       out  1  qualifies pkt_end: 1 = clean EOP, bit count %8==0, no stuff/SE1 error
//  usb_bus_reset  out  1  level: SE0 held >= RESET_CYCLES clocks, clears on first non-SE0 sample
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; phase 0; line history = J; counters 0.
//  Line state from synced (p,n): J=10, K=01, SE0=00, SE1=11.
//  DPLL: 2-bit phase.
//   - On a change of synced line state: phase<=1; otherwise phase<=phase+1 (wraps 3->0).
//   - bit_strobe is asserted when phase==2 and samples the line state.
//   - Tolerates +/-1 clock of edge jitter per bit.
//  NRZI: at bit_strobe, bit = (line == prev_sampled_line) ? 1 : 0; prev updated every strobe.
//  FSM states IDLE, DATA, EOP, ERR.
//   IDLE -> DATA: sampled line history ends K,J,K,J,K,K. Leading sync bits may be lost.
//    - pkt_start pulses the clock after that strobe; bit/stuff counters cleared.
//   DATA:
//    - Each unstuffed bit shifts into byte reg (MSB-in, LSB-first result).
//    - 8th bit: rx_data updated, rx_data_put pulses the next clock.
//    - Stuffing: count consecutive 1s. After 6, the next bit is dropped.
//    - If the dropped bit is 1 -> ERR.
//   DATA -> EOP: strobe samples SE0.
//   DATA -> ERR: strobe samples SE1.
//   EOP -> IDLE:
//    - The next strobe must be SE0, then a J is required.
//    - On J: pkt_end pulses with pkt_good = (bits%8==0).
//    - Single SE0 followed by J/K -> ERR.
//   ERR: pkt_end pulses once with pkt_good=0, no further rx_data_put.
//    - Then wait for SE0 followed by J (or rx_en low) -> IDLE.
//  rx_data_put and pkt_end are never asserted in the same clock.
//  Final byte put precedes pkt_end by >=4 clocks.
//  rx_en=0 mid-packet: abort to IDLE immediately, no pkt_end.
//  reset_n=0 mid-packet: same, outputs 0 on next edge.
//  usb_bus_reset:
//   - The SE0 counter saturates at RESET_CYCLES.
//   - Counts in any state, independent of rx_en.
//   - Bus reset forces the FSM to IDLE without pkt_end.
//  Latency: pin edge -> bit_strobe <= SYNC_STAGES+3 clocks; strobe -> put/start/end = 1 clock.
// TESTING
//  1 SYNC + ACK 0xD2 + SE0,SE0,J at 83333 ps/bit:
//    -> pkt_start x1, one put rx_data=0xD2, pkt_end with pkt_good=1.
//  2 DATA0 payload FF FF (stuffed bits inserted by host):
//    -> puts C3,FF,FF,crc_lo,crc_hi; stuffed bits dropped; pkt_good=1.
//  3 Seven 1s with no stuffed 0 inside a DATA0:
//    -> pkt_end pulse pkt_good=0 within 2 bit times; no later puts.
//  4 SYNC + 12 data bits + EOP:
//    -> one put, pkt_end with pkt_good=0.
//  5 SE0 for 130 clocks then J:
//    -> usb_bus_reset rises at clock 120+SYNC_STAGES, falls after J synced.
//  6 Drift/abort:
//    - 83328 ps and 83340 ps bit periods over a 64-byte packet -> all bytes correct.
//    - reset_n low mid-packet -> no pkt_end; next ACK received cleanly.

Source files
------------

// File: rtl/usb_fs_rx_decoder.sv
`timescale 1ps/1ps
// usb_fs_rx_decoder: full-speed USB receive front end recovering bits from 4x oversampled D+/D-,
// with NRZI decode, SYNC detect, bit-unstuffing, EOP framing and bus-reset detect.
module usb_fs_rx_decoder #(
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_CYCLES = 120
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    input  logic       rx_en,
    output logic       pkt_start,
    output logic [7:0] rx_data,
    output logic       rx_data_put,
    output logic       pkt_end,
    output logic       pkt_good,
    output logic       usb_bus_reset
);
    localparam logic [1:0] SE0 = 2'b00, K = 2'b01, J = 2'b10, SE1 = 2'b11;
    localparam logic [11:0] SYNC_PAT = {K, J, K, J, K, K};
    localparam int CW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, EOP, ERR} state_t;

    logic [SYNC_STAGES-1:0] p_sync, n_sync;
    logic [1:0] line, line_prev, sampled, phase;
    logic [9:0] hist;
    logic [11:0] hist_next;
    logic [CW-1:0] se0_cnt;
    logic [6:0] shift;
    logic [2:0] bit_cnt, ones;
    logic strobe, nrzi_bit, eop_se0;
    state_t state;

    assign line      = {p_sync[SYNC_STAGES-1], n_sync[SYNC_STAGES-1]};
    assign strobe    = phase == 2'd2;
    assign nrzi_bit  = line == sampled;
    assign hist_next = {hist, line};

    // Synchroniser, DPLL phase and SE0 duration counter run regardless of rx_en
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            p_sync        <= '1;
            n_sync        <= '0;
            line_prev     <= J;
            phase         <= '0;
            se0_cnt       <= '0;
            usb_bus_reset <= 1'b0;
        end else begin
            p_sync        <= {p_sync[SYNC_STAGES-2:0], usb_p_rx};
            n_sync        <= {n_sync[SYNC_STAGES-2:0], usb_n_rx};
            line_prev     <= line;
            phase         <= (line != line_prev) ? 2'd1 : phase + 2'd1;
            se0_cnt       <= (line != SE0) ? '0 : (se0_cnt == CW'(RESET_CYCLES)) ? se0_cnt : se0_cnt + 1'b1;
            usb_bus_reset <= line == SE0 && se0_cnt >= CW'(RESET_CYCLES - 1);
        end
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state       <= IDLE;
            hist        <= {5{J}};
            sampled     <= J;
            shift       <= '0;
            bit_cnt     <= '0;
            ones        <= '0;
            eop_se0     <= 1'b0;
            pkt_start   <= 1'b0;
            rx_data     <= '0;
            rx_data_put <= 1'b0;
            pkt_end     <= 1'b0;
            pkt_good    <= 1'b0;
        end else begin
            pkt_start   <= 1'b0;
            rx_data_put <= 1'b0;
            pkt_end     <= 1'b0;
            pkt_good    <= 1'b0;
            if (strobe) begin
                sampled <= line;
                hist    <= hist_next[9:0];
            end
            if (!rx_en || usb_bus_reset) begin
                state <= IDLE;
                hist  <= {5{J}};
            end else if (strobe) begin
                case (state)
                    IDLE: if (hist_next == SYNC_PAT) begin
                        state     <= DATA;
                        pkt_start <= 1'b1;
                        bit_cnt   <= '0;
                        ones      <= '0;
                    end
                    DATA: if (line == SE0) begin
                        state   <= EOP;
                        eop_se0 <= 1'b0;
                    end else if (line == SE1) begin
                        state   <= ERR;
                        pkt_end <= 1'b1;
                    end else if (ones == 3'd6) begin
                        // stuff position: a 0 is discarded, a 1 is a stuffing violation
                        ones <= '0;
                        if (nrzi_bit) begin
                            state   <= ERR;
                            pkt_end <= 1'b1;
                        end
                    end else begin
                        ones    <= nrzi_bit ? ones + 3'd1 : 3'd0;
                        shift   <= {nrzi_bit, shift[6:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data     <= {nrzi_bit, shift};
                            rx_data_put <= 1'b1;
                        end
                    end
                    EOP: if (line == SE0) begin
                        eop_se0 <= 1'b1;
                    end else if (line == J && eop_se0) begin
                        state    <= IDLE;
                        pkt_end  <= 1'b1;
                        pkt_good <= bit_cnt == 3'd0;
                    end else begin
                        state   <= ERR;
                        pkt_end <= 1'b1;
                    end
                    ERR: if (line == J && sampled == SE0) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_fs_rx_decoder.sv
`timescale 1ps/1ps
// tb_usb_fs_rx_decoder: drives NRZI-encoded packets onto D+/D- and compares the decoded
// byte stream and framing against a reference built directly from the logical payload bits.
module tb_usb_fs_rx_decoder;
    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
    localparam int NOM = 83333;
    localparam int CLK_PS = 20833;
    localparam int SYNC_STAGES = 2;
    localparam int RESET_CYCLES = 120;

    logic clk_48mhz = 1'b0, reset_n = 1'b0, usb_p_rx = 1'b1, usb_n_rx = 1'b0, rx_en = 1'b1;
    logic pkt_start, rx_data_put, pkt_end, pkt_good, usb_bus_reset;
    logic [7:0] rx_data;

    int total = 0, bad = 0;
    int starts = 0, ends = 0, overlap = 0;
    int st0, en0, gb;
    bit last_good;
    time t_end, t_put, t_mark;
    logic [7:0] got_q[$], exp_q[$];
    bit bits_q[$];
    logic [1:0] lvl;

    usb_fs_rx_decoder #(.SYNC_STAGES(SYNC_STAGES), .RESET_CYCLES(RESET_CYCLES)) dut (
        .clk_48mhz(clk_48mhz), .reset_n(reset_n), .usb_p_rx(usb_p_rx), .usb_n_rx(usb_n_rx),
        .rx_en(rx_en), .pkt_start(pkt_start), .rx_data(rx_data), .rx_data_put(rx_data_put),
        .pkt_end(pkt_end), .pkt_good(pkt_good), .usb_bus_reset(usb_bus_reset)
    );

    always begin
        #10416 clk_48mhz = 1'b1;
        #10417 clk_48mhz = 1'b0;
    end

    always @(negedge clk_48mhz) begin
        if (pkt_start) starts++;
        if (rx_data_put) begin
            got_q.push_back(rx_data);
            t_put = $time;
        end
        if (pkt_end) begin
            ends++;
            last_good = pkt_good;
            t_end = $time;
        end
        if (rx_data_put && pkt_end) overlap++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input int per);
        {usb_p_rx, usb_n_rx} = s;
        #(per);
    endtask

    task automatic emit(input bit b, input int per);
        if (!b) lvl = (lvl == J) ? K : J;
        drive(lvl, per);
    endtask

    // Host side: idle, SYNC, payload with optional stuffing, optional EOP; mark/abort by payload index
    task automatic send(input int per, input bit stuff, input bit eop, input int mark, input int abort_at);
        int run = 0;
        lvl = J;
        repeat (8) drive(J, per);
        repeat (7) emit(1'b0, per);
        emit(1'b1, per);
        foreach (bits_q[i]) begin
            if (i == abort_at) begin
                @(negedge clk_48mhz) reset_n = 1'b0;
                repeat (3) @(negedge clk_48mhz);
                chk("abort_rst_data", rx_data, 0);
                chk("abort_rst_outs", {pkt_start, rx_data_put, pkt_end, pkt_good, usb_bus_reset}, 0);
                reset_n = 1'b1;
            end
            if (i == mark) t_mark = $time;
            emit(bits_q[i], per);
            run = bits_q[i] ? run + 1 : 0;
            if (stuff && run == 6) begin
                emit(1'b0, per);
                run = 0;
            end
        end
        if (eop) begin
            drive(SE0, per);
            drive(SE0, per);
            lvl = J;
            repeat (8) drive(J, per);
        end
    endtask

    task automatic add_byte(input logic [7:0] v);
        for (int k = 0; k < 8; k++) bits_q.push_back(v[k]);
    endtask

    task automatic rand_bits(input int n);
        bits_q = {};
        repeat (n) bits_q.push_back(1'($urandom_range(0, 1)));
    endtask

    // Reference: every complete group of 8 payload bits is one byte, first bit in the LSB
    task automatic model(output bit good);
        exp_q = {};
        for (int b = 0; b + 8 <= bits_q.size(); b += 8) begin
            logic [7:0] v;
            for (int k = 0; k < 8; k++) v[k] = bits_q[b + k];
            exp_q.push_back(v);
        end
        good = bits_q.size() % 8 == 0;
    endtask

    task automatic begin_pkt();
        st0 = starts;
        en0 = ends;
        gb = got_q.size();
    endtask

    task automatic check_pkt(input string tag, input int n_start, input int n_end, input bit good);
        chk({tag, "_start"}, starts - st0, n_start);
        chk({tag, "_nput"}, got_q.size() - gb, exp_q.size());
        foreach (exp_q[i])
            if (gb + i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), got_q[gb + i], exp_q[i]);
        chk({tag, "_end"}, ends - en0, n_end);
        if (n_end > 0 && ends > en0) begin
            chk({tag, "_good"}, last_good, good);
            if (good && exp_q.size() > 0) chk({tag, "_put_gap"}, (t_end - t_put) >= 4 * CLK_PS, 1);
        end
    endtask

    task automatic run_pkt(input string tag, input int per);
        bit good;
        model(good);
        begin_pkt();
        send(per, 1'b1, 1'b1, -1, -1);
        check_pkt(tag, 1, 1, good);
    endtask

    function automatic logic [15:0] crc16(input logic [7:0] d[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (d[i])
            for (int k = 0; k < 8; k++)
                c = (c[0] ^ d[i][k]) ? (c >> 1) ^ 16'hA001 : c >> 1;
        return ~c;
    endfunction

    initial begin
        logic [7:0] pl[$];
        logic [15:0] crc;
        repeat (4) @(negedge clk_48mhz);
        chk("reset_outs", {pkt_start, rx_data_put, pkt_end, pkt_good, usb_bus_reset}, 0);
        chk("reset_data", rx_data, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_48mhz);

        bits_q = {};
        add_byte(8'hD2);
        run_pkt("ack", NOM);

        pl = '{8'hFF, 8'hFF};
        crc = crc16(pl);
        bits_q = {};
        add_byte(8'hC3);
        add_byte(8'hFF);
        add_byte(8'hFF);
        add_byte(crc[7:0]);
        add_byte(crc[15:8]);
        run_pkt("data0_ff", NOM);

        // Seven consecutive 1s without stuffing: error on payload bit 12, C3 already delivered
        bits_q = {};
        add_byte(8'hC3);
        add_byte(8'hFF);
        exp_q = '{8'hC3};
        begin_pkt();
        send(NOM, 1'b0, 1'b1, 12, -1);
        check_pkt("stuff_err", 1, 1, 1'b0);
        chk("stuff_err_latency", (t_end - t_mark) <= 2 * NOM, 1);

        rand_bits(12);
        run_pkt("bits12", NOM);

        for (int n = 0; n < 6; n++) begin
            rand_bits(8 * $urandom_range(1, 8));
            run_pkt($sformatf("rand%0d", n), NOM);
        end
        for (int n = 0; n < 2; n++) begin
            rand_bits($urandom_range(9, 40));
            run_pkt($sformatf("randlen%0d", n), NOM);
        end

        rand_bits(512);
        run_pkt("drift_slow", 83340);
        rand_bits(512);
        run_pkt("drift_fast", 83328);

        // Reset mid-packet: remaining bits are zeros so nothing after the abort resembles SYNC
        bits_q = {};
        add_byte(8'hD2);
        add_byte(8'h00);
        add_byte(8'h00);
        exp_q = '{8'hD2};
        begin_pkt();
        send(NOM, 1'b1, 1'b1, -1, 12);
        check_pkt("abort", 1, 0, 1'b0);
        bits_q = {};
        add_byte(8'hD2);
        run_pkt("after_abort", NOM);

        rx_en = 1'b0;
        rand_bits(16);
        exp_q = {};
        begin_pkt();
        send(NOM, 1'b1, 1'b1, -1, -1);
        check_pkt("rx_en_off", 0, 0, 1'b0);
        rx_en = 1'b1;

        // Packet interrupted by long SE0: bus reset returns to IDLE with no pkt_end
        bits_q = {};
        add_byte(8'hA5);
        exp_q = '{8'hA5};
        begin_pkt();
        send(NOM, 1'b1, 1'b0, -1, -1);
        @(negedge clk_48mhz) {usb_p_rx, usb_n_rx} = SE0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk_48mhz);
            if (k == RESET_CYCLES + SYNC_STAGES - 1) chk("bus_rst_early", usb_bus_reset, 0);
            if (k == RESET_CYCLES + SYNC_STAGES) chk("bus_rst_rise", usb_bus_reset, 1);
        end
        {usb_p_rx, usb_n_rx} = J;
        repeat (SYNC_STAGES) @(negedge clk_48mhz);
        chk("bus_rst_hold", usb_bus_reset, 1);
        @(negedge clk_48mhz);
        chk("bus_rst_fall", usb_bus_reset, 0);
        repeat (32) @(negedge clk_48mhz);
        check_pkt("bus_rst_pkt", 1, 0, 1'b0);

        bits_q = {};
        add_byte(8'hD2);
        run_pkt("after_bus_rst", NOM);

        chk("put_end_same_clk", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
